// File: rtl/uart_axil_reg_bridge_if.sv
// AXI4-Lite channel bundle between the chipset-side master and the UART register bridge.
// Carries the five AXI-Lite channels (aw, w, b, ar, r) without wstrb/prot.
//   master modport: drives addresses, data, valids and response readies.
//   slave modport : drives address/data readies, responses and read data.
interface uart_axil_reg_bridge_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/uart_axil_reg_bridge.sv
// AXI4-Lite slave terminating the chipset-side UART port and converting each
// access into a single-outstanding req/ack register transaction to the UART core.
// A core that fails to ack within TIMEOUT_CYCLES gets the access completed with
// SLVERR so the host never stalls.
// Ports:
//   chipset_clk, chipset_rst_n : clock, synchronous active-low reset
//   s_axi                      : AXI-Lite slave channels (aw, w, b, ar, r)
//   reg_req/reg_we/reg_addr/reg_wdata : request towards the core, held until ack/timeout
//   reg_ack/reg_rdata/reg_err  : one-cycle completion strobe with read data and error flag
module uart_axil_reg_bridge #(
  parameter int ADDR_W         = 13,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  chipset_clk,
  input  logic                  chipset_rst_n,
  uart_axil_reg_bridge_if.slave s_axi,
  output logic                  reg_req,
  output logic                  reg_we,
  output logic [ADDR_W-1:0]     reg_addr,
  output logic [DATA_W-1:0]     reg_wdata,
  input  logic                  reg_ack,
  input  logic [DATA_W-1:0]     reg_rdata,
  input  logic                  reg_err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REG_WR  = 3'd1;
  localparam logic [2:0] REG_RD  = 3'd2;
  localparam logic [2:0] WR_RESP = 3'd3;
  localparam logic [2:0] RD_RESP = 3'd4;

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]        state;
  logic              aw_held, w_held, ar_held;
  logic [ADDR_W-1:0] aw_addr_q, ar_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic              last_rd;
  logic [TMR_W-1:0]  timer;
  logic              bvalid_q, rvalid_q;
  logic [1:0]        bresp_q, rresp_q;
  logic [DATA_W-1:0] rdata_q;

  logic idle, wr_pend, rd_pend, grant_wr, grant_rd, done, timed_out;
  logic aw_fire, w_fire, ar_fire;
  logic [1:0] done_resp;

  assign idle    = (state == IDLE);
  assign wr_pend = aw_held && w_held;
  assign rd_pend = ar_held;
  // Round-robin only matters when both are pending: last_rd=1 hands the slot to the write.
  assign grant_wr = idle && wr_pend && (!rd_pend || last_rd);
  assign grant_rd = idle && rd_pend && (!wr_pend || !last_rd);

  assign timed_out = (timer == TMR_W'(TIMEOUT_CYCLES));
  // An ack arriving in the timeout cycle still wins over the timeout.
  assign done      = reg_ack || timed_out;
  assign done_resp = (reg_ack && !reg_err) ? 2'b00 : 2'b10;

  // Readies are gated by reset so they read 0 while the bridge is held in reset.
  assign s_axi.awready = chipset_rst_n && idle && !aw_held;
  assign s_axi.wready  = chipset_rst_n && idle && !w_held;
  assign s_axi.arready = chipset_rst_n && idle && !ar_held;

  assign aw_fire = s_axi.awvalid && s_axi.awready;
  assign w_fire  = s_axi.wvalid  && s_axi.wready;
  assign ar_fire = s_axi.arvalid && s_axi.arready;

  assign s_axi.bvalid = bvalid_q;
  assign s_axi.bresp  = bresp_q;
  assign s_axi.rvalid = rvalid_q;
  assign s_axi.rresp  = rresp_q;
  assign s_axi.rdata  = rdata_q;

  always_ff @(posedge chipset_clk) begin
    if (!chipset_rst_n) begin
      state     <= IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      ar_held   <= 1'b0;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      w_data_q  <= '0;
      last_rd   <= 1'b0;
      timer     <= '0;
      reg_req   <= 1'b0;
      reg_we    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      // Capture and grant-clear never collide: a channel is only accepted while its holder is empty.
      if (aw_fire) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_axi.awaddr;
      end
      if (w_fire) begin
        w_held   <= 1'b1;
        w_data_q <= s_axi.wdata;
      end
      if (ar_fire) begin
        ar_held   <= 1'b1;
        ar_addr_q <= s_axi.araddr;
      end

      case (state)
        IDLE: begin
          if (grant_wr) begin
            state     <= REG_WR;
            reg_req   <= 1'b1;
            reg_we    <= 1'b1;
            reg_addr  <= aw_addr_q;
            reg_wdata <= w_data_q;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            timer     <= TMR_W'(1);
          end else if (grant_rd) begin
            state    <= REG_RD;
            reg_req  <= 1'b1;
            reg_we   <= 1'b0;
            reg_addr <= ar_addr_q;
            ar_held  <= 1'b0;
            timer    <= TMR_W'(1);
          end
        end
        REG_WR: begin
          if (done) begin
            reg_req  <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= done_resp;
            state    <= WR_RESP;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        REG_RD: begin
          if (done) begin
            reg_req  <= 1'b0;
            rvalid_q <= 1'b1;
            rresp_q  <= done_resp;
            rdata_q  <= reg_ack ? reg_rdata : '0;
            state    <= RD_RESP;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        WR_RESP: begin
          if (s_axi.bready) begin
            bvalid_q <= 1'b0;
            last_rd  <= 1'b0;
            state    <= IDLE;
          end
        end
        RD_RESP: begin
          if (s_axi.rready) begin
            rvalid_q <= 1'b0;
            last_rd  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_axil_reg_bridge.sv
module tb_uart_axil_reg_bridge;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int TMO    = 16;

  logic              clk;
  logic              rst_n;
  logic              reg_req, reg_we;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_ack;
  logic [DATA_W-1:0] reg_rdata;
  logic              reg_err;

  uart_axil_reg_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_axi ();

  uart_axil_reg_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
    .chipset_clk   (clk),
    .chipset_rst_n (rst_n),
    .s_axi         (s_axi),
    .reg_req       (reg_req),
    .reg_we        (reg_we),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_ack       (reg_ack),
    .reg_rdata     (reg_rdata),
    .reg_err       (reg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Core model settings: ack_dly = N acks in the N-th cycle of reg_req, 0 = never ack.
  int          ack_dly = 1;
  logic [31:0] core_rd = '0;
  logic        core_err = 1'b0;

  // Request / response monitor state.
  int          cnt = 0;
  int          mon_reqs = 0;
  int          req_hi = 0;
  int          stab_err = 0;
  int          rv_seen = 0;
  int          rsp_n = 0;
  logic        log_we[4];
  logic [12:0] log_addr[4];
  logic [2:0]  rsp_log[4];
  logic        mon_we;
  logic [12:0] mon_addr;
  logic [31:0] mon_wdata;

  // Core responder and monitor, acting 2 time units after each rising edge.
  always begin
    @(posedge clk);
    #2;
    if (!rst_n || reg_ack) begin
      reg_ack = 1'b0;
      cnt = 0;
    end else if (reg_req) begin
      if (cnt == 0) begin
        mon_we = reg_we;
        mon_addr = reg_addr;
        mon_wdata = reg_wdata;
        if (mon_reqs < 4) begin
          log_we[mon_reqs] = reg_we;
          log_addr[mon_reqs] = reg_addr;
        end
        mon_reqs++;
      end else if (reg_we !== mon_we || reg_addr !== mon_addr || reg_wdata !== mon_wdata) begin
        stab_err++;
      end
      cnt++;
      req_hi++;
      if (cnt == ack_dly) begin
        reg_ack = 1'b1;
        reg_rdata = core_rd;
        reg_err = core_err;
      end
    end else begin
      cnt = 0;
    end
    if (s_axi.rvalid) rv_seen++;
    if (s_axi.bvalid && s_axi.bready && rsp_n < 4) begin
      rsp_log[rsp_n] = {1'b0, s_axi.bresp};
      rsp_n++;
    end
    if (s_axi.rvalid && s_axi.rready && rsp_n < 4) begin
      rsp_log[rsp_n] = {1'b1, s_axi.rresp};
      rsp_n++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic clear_mon();
    mon_reqs = 0;
    req_hi = 0;
    stab_err = 0;
    rv_seen = 0;
    rsp_n = 0;
  endtask

  task automatic do_write(input logic [12:0] a, input logic [31:0] d);
    int n;
    logic aw_go, w_go;
    s_axi.awaddr = a;
    s_axi.wdata = d;
    s_axi.awvalid = 1'b1;
    s_axi.wvalid = 1'b1;
    n = 0;
    while ((s_axi.awvalid || s_axi.wvalid) && n < 200) begin
      aw_go = s_axi.awvalid && s_axi.awready;
      w_go = s_axi.wvalid && s_axi.wready;
      @(negedge clk);
      n++;
      if (aw_go) s_axi.awvalid = 1'b0;
      if (w_go) s_axi.wvalid = 1'b0;
    end
    if (n >= 200) begin
      bound_fail("wr_handshake");
      s_axi.awvalid = 1'b0;
      s_axi.wvalid = 1'b0;
    end
  endtask

  task automatic do_read(input logic [12:0] a);
    int n;
    s_axi.araddr = a;
    s_axi.arvalid = 1'b1;
    n = 0;
    while (!s_axi.arready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    s_axi.arvalid = 1'b0;
    if (n >= 200) bound_fail("rd_handshake");
  endtask

  // Called in the cycle after the address handshake; lat counts cycles from the handshake cycle.
  task automatic wait_b(output int lat, output logic [1:0] resp);
    s_axi.bready = 1'b1;
    lat = 1;
    while (!s_axi.bvalid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    resp = s_axi.bresp;
    if (lat >= 300) bound_fail("bvalid_wait");
    @(negedge clk);
    s_axi.bready = 1'b0;
  endtask

  task automatic wait_r(output int lat, output logic [1:0] resp, output logic [31:0] data);
    s_axi.rready = 1'b1;
    lat = 1;
    while (!s_axi.rvalid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    resp = s_axi.rresp;
    data = s_axi.rdata;
    if (lat >= 300) bound_fail("rvalid_wait");
    @(negedge clk);
    s_axi.rready = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [12:0] addr;
    logic [31:0] wdata;
    int          ack_dly;
    logic [31:0] core_rd;
    logic        core_err;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_len;
  } vec_t;

  localparam int NV = 8;
  vec_t vec[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    logic [1:0] resp;
    logic [31:0] rd;

    vec[0] = '{1'b1, 13'h004, 32'h0000_00A5, 1,  32'h0,         1'b0, 2'b00, 32'h0,         1};
    vec[1] = '{1'b0, 13'h008, 32'h0,         5,  32'h0000_1234, 1'b0, 2'b00, 32'h0000_1234, 5};
    vec[2] = '{1'b1, 13'h010, 32'hDEAD_BEEF, 3,  32'h0,         1'b1, 2'b10, 32'h0,         3};
    vec[3] = '{1'b0, 13'h1FFC, 32'h0,        0,  32'hFFFF_FFFF, 1'b0, 2'b10, 32'h0,         TMO};
    vec[4] = '{1'b1, 13'h1FFF, 32'h1357_9BDF, 0, 32'h0,         1'b0, 2'b10, 32'h0,         TMO};
    vec[5] = '{1'b0, 13'h000, 32'h0,         TMO, 32'hCAFE_F00D, 1'b0, 2'b00, 32'hCAFE_F00D, TMO};
    vec[6] = '{1'b0, 13'h020, 32'h0,         2,  32'h0000_0055, 1'b1, 2'b10, 32'h0000_0055, 2};
    vec[7] = '{1'b1, 13'h0AA, 32'h8000_0001, 15, 32'h0,         1'b0, 2'b00, 32'h0,         15};

    rst_n = 1'b0;
    reg_ack = 1'b0;
    reg_rdata = '0;
    reg_err = 1'b0;
    s_axi.awaddr = '0;  s_axi.awvalid = 1'b0;
    s_axi.wdata = '0;   s_axi.wvalid = 1'b0;
    s_axi.bready = 1'b0;
    s_axi.araddr = '0;  s_axi.arvalid = 1'b0;
    s_axi.rready = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_awready", {31'b0, s_axi.awready}, 32'h0);
    chk("rst_wready", {31'b0, s_axi.wready}, 32'h0);
    chk("rst_arready", {31'b0, s_axi.arready}, 32'h0);
    chk("rst_valids_req", {29'b0, s_axi.bvalid, s_axi.rvalid, reg_req}, 32'h0);
    chk("rst_resps", {28'b0, s_axi.bresp, s_axi.rresp}, 32'h0);
    chk("rst_rdata", s_axi.rdata, 32'h0);
    chk("rst_reg_addr", {19'b0, reg_addr}, 32'h0);
    chk("rst_reg_wdata", reg_wdata, 32'h0);

    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_awready", {31'b0, s_axi.awready}, 32'h1);

    // Table-driven single transactions.
    for (int i = 0; i < NV; i++) begin
      ack_dly = vec[i].ack_dly;
      core_rd = vec[i].core_rd;
      core_err = vec[i].core_err;
      clear_mon();
      rd = '0;
      if (vec[i].wr) begin
        do_write(vec[i].addr, vec[i].wdata);
        wait_b(lat, resp);
      end else begin
        do_read(vec[i].addr);
        wait_r(lat, resp, rd);
      end
      chk($sformatf("v%0d_resp", i), {30'b0, resp}, {30'b0, vec[i].exp_resp});
      chk($sformatf("v%0d_latency", i), lat, vec[i].exp_len + 2);
      chk($sformatf("v%0d_req_cycles", i), req_hi, vec[i].exp_len);
      chk($sformatf("v%0d_req_count", i), mon_reqs, 1);
      chk($sformatf("v%0d_reg_we", i), {31'b0, mon_we}, {31'b0, vec[i].wr});
      chk($sformatf("v%0d_reg_addr", i), {19'b0, mon_addr}, {19'b0, vec[i].addr});
      if (vec[i].wr) chk($sformatf("v%0d_reg_wdata", i), mon_wdata, vec[i].wdata);
      else chk($sformatf("v%0d_rdata", i), rd, vec[i].exp_rdata);
      chk($sformatf("v%0d_req_stable", i), stab_err, 0);
      repeat (2) @(negedge clk);
    end

    // w arrives 4 cycles before aw.
    clear_mon();
    ack_dly = 1;
    core_err = 1'b0;
    s_axi.wdata = 32'h600D_F00D;
    s_axi.wvalid = 1'b1;
    @(negedge clk);
    s_axi.wvalid = 1'b0;
    chk("wfirst_wready_low", {31'b0, s_axi.wready}, 32'h0);
    repeat (4) @(negedge clk);
    chk("wfirst_no_req", mon_reqs, 0);
    s_axi.awaddr = 13'h00C;
    s_axi.awvalid = 1'b1;
    @(negedge clk);
    s_axi.awvalid = 1'b0;
    wait_b(lat, resp);
    chk("wfirst_latency", lat, 3);
    chk("wfirst_bresp", {30'b0, resp}, 32'h0);
    chk("wfirst_req_count", mon_reqs, 1);
    chk("wfirst_addr", {19'b0, mon_addr}, 32'h00C);
    chk("wfirst_wdata", mon_wdata, 32'h600D_F00D);
    repeat (2) @(negedge clk);

    // Simultaneous ar and aw+w from reset: arbitration order and SLVERR on reg_err.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s_axi.bready = 1'b1;
    s_axi.rready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      clear_mon();
      ack_dly = 1;
      core_err = (r == 1);
      core_rd = 32'h77;
      s_axi.awaddr = (r == 0) ? 13'h040 : 13'h050;
      s_axi.araddr = (r == 0) ? 13'h030 : 13'h060;
      s_axi.wdata = 32'h11;
      s_axi.awvalid = 1'b1;
      s_axi.wvalid = 1'b1;
      s_axi.arvalid = 1'b1;
      @(negedge clk);
      s_axi.awvalid = 1'b0;
      s_axi.wvalid = 1'b0;
      s_axi.arvalid = 1'b0;
      repeat (12) @(negedge clk);
      chk($sformatf("arb%0d_req_count", r), mon_reqs, 2);
      chk($sformatf("arb%0d_first_we", r), {31'b0, log_we[0]}, 32'h0);
      chk($sformatf("arb%0d_first_addr", r), {19'b0, log_addr[0]}, (r == 0) ? 32'h030 : 32'h060);
      chk($sformatf("arb%0d_second_we", r), {31'b0, log_we[1]}, 32'h1);
      chk($sformatf("arb%0d_second_addr", r), {19'b0, log_addr[1]}, (r == 0) ? 32'h040 : 32'h050);
      chk($sformatf("arb%0d_rsp_count", r), rsp_n, 2);
      chk($sformatf("arb%0d_rsp0", r), {29'b0, rsp_log[0]}, (r == 0) ? 32'h4 : 32'h6);
      chk($sformatf("arb%0d_rsp1", r), {29'b0, rsp_log[1]}, (r == 0) ? 32'h0 : 32'h2);
    end
    s_axi.bready = 1'b0;
    s_axi.rready = 1'b0;
    core_err = 1'b0;
    @(negedge clk);

    // rready held low for 10 cycles: response must hold steady.
    clear_mon();
    ack_dly = 1;
    core_rd = 32'h0BAD_CAFE;
    do_read(13'h044);
    n = 0;
    while (!s_axi.rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) bound_fail("hold_rvalid_wait");
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("hold%0d_rvalid", k), {31'b0, s_axi.rvalid}, 32'h1);
      chk($sformatf("hold%0d_rdata", k), s_axi.rdata, 32'h0BAD_CAFE);
      @(negedge clk);
    end
    chk("hold_rresp", {30'b0, s_axi.rresp}, 32'h0);
    chk("hold_arready_low", {31'b0, s_axi.arready}, 32'h0);
    s_axi.rready = 1'b1;
    @(negedge clk);
    s_axi.rready = 1'b0;
    chk("hold_rvalid_drop", {31'b0, s_axi.rvalid}, 32'h0);
    repeat (2) @(negedge clk);

    // Reset in the middle of a register read.
    clear_mon();
    ack_dly = 0;
    do_read(13'h048);
    repeat (3) @(negedge clk);
    chk("midrst_req_high", {31'b0, reg_req}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_req_drop", {31'b0, reg_req}, 32'h0);
    chk("midrst_rvalid", {31'b0, s_axi.rvalid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (TMO + 8) @(negedge clk);
    chk("midrst_no_rvalid", rv_seen, 0);
    chk("midrst_req_after", {31'b0, reg_req}, 32'h0);
    chk("midrst_arready_idle", {31'b0, s_axi.arready}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
